aes_round_engine: RTL and testbench
===================================

# aes_round_engine

Iterative AES-128 encryption datapath that consumes the 11-round-key schedule from the key-expansion stage. It runs one round per clock over a registered 128-bit state. A valid/ready pair on each side connects it to a plaintext source and a ciphertext sink. It instantiates 16 copies of the existing `sbox` for SubBytes and performs one block at a time with no overlap.

## Interface
- Parameters: none; AES-128 only, with 10 rounds fixed.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  `plaintext` and `round_keys` are valid.
- `in_ready`  out  1  engine can accept a block; high only in IDLE.
- `plaintext`  in  128  input block.
  - FIPS-197 byte order: byte n is at bits [127-8n : 120-8n].
  - Column c is bytes 4c..4c+3.
- `round_keys`  in  1408  expanded schedule.
  - Round key r is at [1407-128r : 1280-128r], for r = 0..10.
  - Round key 0 is the cipher key.
- `out_valid`  out  1  `ciphertext` is valid.
- `out_ready`  in  1  sink accepts `ciphertext`.
- `ciphertext`  out  128  result, in the same byte order as `plaintext`.
- `busy`  out  1  high in ROUND or DONE.

## Operation
- FSM states: IDLE → ROUND → DONE → IDLE.
- Accept: in IDLE, if `in_valid` is high, the engine latches the block at that edge.
  - state ← `plaintext` ^ rk0 (initial AddRoundKey).
  - All 1408 bits of `round_keys` are registered internally.
  - rnd ← 1; go to ROUND.
  - The source may change its inputs after the accept edge.
- ROUND, each edge:
  - state ← AddRoundKey(MixColumns(ShiftRows(SubBytes(state))), rk[rnd]); rnd ← rnd+1.
  - When rnd = 10, MixColumns is omitted and the FSM moves to DONE.
- SubBytes: the `sbox` module applied to each byte.
- ShiftRows: row r (bytes r, r+4, r+8, r+12) is rotated left by r columns.
- MixColumns:
  - Per column, multiply by the matrix [2 3 1 1; 1 2 3 1; 1 1 2 3; 3 1 1 2] over GF(2^8).
  - xtime(b) = {b[6:0],0} ^ (b[7] ? 8'h1b : 0).
- rnd is a 4-bit counter; values 11..15 are unreachable.
- DONE:
  - `out_valid` = 1 and `ciphertext` = state.
  - When `out_valid` && `out_ready` at an edge, go to IDLE.
- Inputs are ignored outside IDLE (`in_ready` = 0). No input buffering.
- Simultaneous output handshake and new `in_valid`: there is no same-cycle accept. The new block is accepted at the first IDLE edge.

## Timing
- Reset values: state=0, rnd=0, FSM=IDLE, `in_ready`=1, `out_valid`=0, `ciphertext`=0, `busy`=0.
- Latency: with the accept edge at k, `out_valid` rises after edge k+10, so it is first sampled high at edge k+11.
- Throughput: at most 1 block per 12 cycles with `out_ready` tied high.
  - 1 accept edge, 10 round edges, 1 output edge.
- Backpressure: while `out_valid` && !`out_ready`, `ciphertext` and `out_valid` hold stable indefinitely.
- `rst` in any state, including mid-ROUND or stalled in DONE:
  - At that edge, return to reset values.
  - The partial block is discarded and no `out_valid` is produced for it.
- `rst` asserted in the same cycle as `in_valid`: reset wins and nothing is accepted.
- All outputs are registered or decoded from FSM state only; there is no combinational path from inputs to outputs.

## Test plan
- FIPS-197 App. B:
  - Stimulus: schedule from key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734.
  - Required: ct 3925841d02dc09fbdc118597196a0b32, with `out_valid` rising exactly 10 edges after accept.
  - Also check the internal state after edge k is 193de3bea0f4e22b9ac68d2ae9f84808.
- FIPS-197 App. C.1:
  - Stimulus: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff.
  - Required: ct 69c4e0d86a7b0430d8cdb78070b4c55a.
- All-zero key and pt → 66e94bd4ef8a2c3b884cfa59ca342b2e.
  - Then hold `out_ready`=0 for 20 cycles: `ciphertext` stays stable and `in_ready` stays 0.
  - Extra `in_valid` pulses during this time are ignored.
- Back-to-back blocks (App. B then App. C.1) with `in_valid` and `out_ready` held high, and inputs changed right after each accept:
  - Both ciphertexts are correct.
  - The second accept occurs 1 cycle after the first output handshake.
- Reset abort:
  - Stimulus: assert `rst` one cycle at round 5 of an App. B block.
  - Required: next cycle `in_ready`=1, `out_valid`=0, `ciphertext`=0, and no stale output appears.
  - A fresh App. C.1 block after the reset completes correctly.

Source files
------------

// File: rtl/aes_round_engine_if.sv
// Handshake bundle between a plaintext source / ciphertext sink and the AES-128 round engine.
interface aes_round_engine_if;
    logic            in_valid;
    logic            in_ready;
    logic [127:0]    plaintext;
    logic [1407:0]   round_keys;
    logic            out_valid;
    logic            out_ready;
    logic [127:0]    ciphertext;
    logic            busy;

    modport master (
        output in_valid, plaintext, round_keys, out_ready,
        input  in_ready, out_valid, ciphertext, busy
    );

    modport slave (
        input  in_valid, plaintext, round_keys, out_ready,
        output in_ready, out_valid, ciphertext, busy
    );
endinterface

// File: rtl/aes_round_engine.sv
// Iterative AES-128 encryption engine: one round per clock over a registered 128-bit state,
// with the full 11-key schedule captured at accept time.
module aes_round_engine (
    input logic               clk,
    input logic               rst,
    aes_round_engine_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ROUND, DONE} fsm_t;

    fsm_t           fsm_q, fsm_d;
    logic [127:0]   state_q, state_d;
    logic [3:0]     rnd_q, rnd_d;
    logic [127:0]   rk_q [11];
    logic [127:0]   rk_d [11];
    logic           in_ready_q, in_ready_d;
    logic           out_valid_q, out_valid_d;
    logic           busy_q, busy_d;

    logic [7:0]     sb [16];
    logic [127:0]   sr;
    logic [127:0]   mc;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mix_column(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = col;
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    for (genvar i = 0; i < 16; i++) begin : g_sbox
        sbox u_sbox (
            .in_byte  (state_q[127-8*i -: 8]),
            .out_byte (sb[i])
        );
    end

    // ShiftRows: output byte (row r, column c) takes input column (c + r) mod 4.
    always_comb begin
        sr = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                sr[127-8*(r+4*c) -: 8] = sb[r + 4*((c + r) % 4)];
            end
        end
    end

    always_comb begin
        mc = '0;
        for (int c = 0; c < 4; c++) begin
            mc[127-32*c -: 32] = mix_column(sr[127-32*c -: 32]);
        end
    end

    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        rnd_d   = rnd_q;
        rk_d    = rk_q;
        case (fsm_q)
            IDLE: begin
                if (bus.in_valid) begin
                    state_d = bus.plaintext ^ bus.round_keys[1407 -: 128];
                    for (int r = 0; r < 11; r++) begin
                        rk_d[r] = bus.round_keys[1407-128*r -: 128];
                    end
                    rnd_d = 4'd1;
                    fsm_d = ROUND;
                end
            end
            ROUND: begin
                // The final round skips MixColumns and parks the counter back at zero.
                if (rnd_q == 4'd10) begin
                    state_d = sr ^ rk_q[rnd_q];
                    rnd_d   = 4'd0;
                    fsm_d   = DONE;
                end else begin
                    state_d = mc ^ rk_q[rnd_q];
                    rnd_d   = rnd_q + 4'd1;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    fsm_d = IDLE;
                end
            end
            default: fsm_d = IDLE;
        endcase
        in_ready_d  = (fsm_d == IDLE);
        out_valid_d = (fsm_d == DONE);
        busy_d      = (fsm_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q       <= IDLE;
            state_q     <= '0;
            rnd_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            fsm_q       <= fsm_d;
            state_q     <= state_d;
            rnd_q       <= rnd_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    // The key store is only ever read after a fresh load, so it needs no reset.
    always_ff @(posedge clk) begin
        rk_q <= rk_d;
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.ciphertext = state_q;
    assign bus.busy       = busy_q;
endmodule

// AES S-box computed as the GF(2^8) inverse (x^254) followed by the affine transform.
module sbox (
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);
    function automatic logic [7:0] sb_xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = sb_xtime(x);
        end
        return p;
    endfunction

    logic [7:0] inv;

    // Exponent 254 = 0b1111_1110: seven square-and-multiply steps, then one square.
    always_comb begin
        inv = 8'h01;
        for (int i = 0; i < 7; i++) begin
            inv = gf_mul(gf_mul(inv, inv), in_byte);
        end
        inv = gf_mul(inv, inv);
        out_byte = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                 ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
endmodule

// File: tb/tb_aes_round_engine.sv
// Self-checking bench for aes_round_engine: FIPS-197 vectors, backpressure, reset abort and random blocks.
module tb_aes_round_engine;
    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;
    logic [7:0] sb_tab [256];

    aes_round_engine_if bus_if ();

    aes_round_engine dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [14:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (15'(a) << i);
        for (int i = 14; i >= 8; i--) if (p[i]) p = p ^ (15'h11b << (i - 8));
        return p[7:0];
    endfunction

    task automatic build_sbox();
        logic [7:0] inv, s, c;
        c = 8'h63;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            for (int i = 0; i < 8; i++)
                s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
            sb_tab[x] = s;
        end
    endtask

    function automatic logic [1407:0] expand(input logic [127:0] key);
        logic [31:0]   w [44];
        logic [31:0]   t;
        logic [7:0]    rc;
        logic [1407:0] rk;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sb_tab[t[31:24]], sb_tab[t[23:16]], sb_tab[t[15:8]], sb_tab[t[7:0]]} ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) rk[1407-128*r -: 128] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        return rk;
    endfunction

    function automatic logic [127:0] model_encrypt(input logic [127:0] key, input logic [127:0] pt);
        logic [1407:0] rk;
        logic [7:0]    s [16];
        logic [7:0]    t [16];
        logic [7:0]    a0, a1, a2, a3;
        logic [127:0]  res;
        rk = expand(key);
        for (int n = 0; n < 16; n++) s[n] = pt[127-8*n -: 8] ^ rk[1407-8*n -: 8];
        for (int r = 1; r <= 10; r++) begin
            for (int n = 0; n < 16; n++) s[n] = sb_tab[s[n]];
            for (int c = 0; c < 4; c++)
                for (int row = 0; row < 4; row++) t[row+4*c] = s[row + 4*((c+row)%4)];
            for (int n = 0; n < 16; n++) s[n] = t[n];
            if (r < 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                    s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
                    s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
                end
            end
            for (int n = 0; n < 16; n++) s[n] = s[n] ^ rk[1407-128*r-8*n -: 8];
        end
        for (int n = 0; n < 16; n++) res[127-8*n -: 8] = s[n];
        return res;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic wait_ready(input string tag);
        int cnt = 0;
        while (!bus_if.in_ready && cnt < 40) begin
            tick();
            cnt++;
        end
        check_val({tag, "_rdy"}, 128'(bus_if.in_ready), 128'd1);
    endtask

    task automatic wait_out(input string tag);
        int cnt = 0;
        while (!bus_if.out_valid && cnt < 30) begin
            tick();
            cnt++;
        end
        check_val({tag, "_lat"}, 128'(cnt), 128'd10);
    endtask

    // One full block with optional stall cycles while the result is held in DONE.
    task automatic run_block(input string tag, input logic [127:0] key, input logic [127:0] pt,
                             input logic [127:0] exp, input int stall,
                             input bit chk_init, input logic [127:0] init_exp);
        logic [127:0] junk;
        bus_if.out_ready  = 1'b0;
        bus_if.plaintext  = pt;
        bus_if.round_keys = expand(key);
        bus_if.in_valid   = 1'b1;
        wait_ready(tag);
        tick();
        if (chk_init) check_val({tag, "_init"}, dut.state_q, init_exp);
        bus_if.in_valid   = 1'b0;
        bus_if.plaintext  = rand128();
        bus_if.round_keys = ~bus_if.round_keys;
        wait_out(tag);
        check_val({tag, "_ct"}, bus_if.ciphertext, exp);
        for (int i = 0; i < stall; i++) begin
            bus_if.in_valid  = 1'($urandom_range(0, 1));
            junk             = rand128();
            bus_if.plaintext = junk;
            tick();
            check_val({tag, "_hold_ct"}, bus_if.ciphertext, exp);
            check_val({tag, "_hold_rdy"}, 128'(bus_if.in_ready), 128'd0);
            check_val({tag, "_hold_vld"}, 128'(bus_if.out_valid), 128'd1);
        end
        bus_if.in_valid  = 1'b0;
        bus_if.out_ready = 1'b1;
        tick();
        check_val({tag, "_drain"}, 128'(bus_if.out_valid), 128'd0);
        bus_if.out_ready = 1'b0;
    endtask

    localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] INI_B = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT_Z  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] k, p;
        bit stale;
        rst               = 1'b1;
        bus_if.in_valid   = 1'b0;
        bus_if.out_ready  = 1'b0;
        bus_if.plaintext  = '0;
        bus_if.round_keys = '0;
        build_sbox();
        repeat (3) tick();
        check_val("rst_in_ready", 128'(bus_if.in_ready), 128'd1);
        check_val("rst_out_valid", 128'(bus_if.out_valid), 128'd0);
        check_val("rst_ct", bus_if.ciphertext, 128'd0);
        check_val("rst_busy", 128'(bus_if.busy), 128'd0);
        rst = 1'b0;
        tick();

        run_block("appB", KEY_B, PT_B, CT_B, 0, 1'b1, INI_B);
        run_block("appC", KEY_C, PT_C, CT_C, 0, 1'b0, '0);
        run_block("zero", '0, '0, CT_Z, 20, 1'b0, '0);

        // Back-to-back with in_valid and out_ready held high.
        bus_if.out_ready  = 1'b1;
        bus_if.in_valid   = 1'b1;
        bus_if.plaintext  = PT_B;
        bus_if.round_keys = expand(KEY_B);
        wait_ready("b2b1");
        tick();
        bus_if.plaintext  = PT_C;
        bus_if.round_keys = expand(KEY_C);
        wait_out("b2b1");
        check_val("b2b1_ct", bus_if.ciphertext, CT_B);
        tick();
        check_val("b2b_idle_rdy", 128'(bus_if.in_ready), 128'd1);
        check_val("b2b_idle_vld", 128'(bus_if.out_valid), 128'd0);
        tick();
        check_val("b2b_acc2_rdy", 128'(bus_if.in_ready), 128'd0);
        check_val("b2b_acc2_busy", 128'(bus_if.busy), 128'd1);
        bus_if.in_valid   = 1'b0;
        bus_if.plaintext  = rand128();
        bus_if.round_keys = ~bus_if.round_keys;
        wait_out("b2b2");
        check_val("b2b2_ct", bus_if.ciphertext, CT_C);
        tick();
        check_val("b2b2_drain", 128'(bus_if.out_valid), 128'd0);
        bus_if.out_ready = 1'b0;

        // Reset at round 5 discards the block.
        bus_if.plaintext  = PT_B;
        bus_if.round_keys = expand(KEY_B);
        bus_if.in_valid   = 1'b1;
        wait_ready("abort");
        tick();
        bus_if.in_valid = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_val("abort_rdy", 128'(bus_if.in_ready), 128'd1);
        check_val("abort_vld", 128'(bus_if.out_valid), 128'd0);
        check_val("abort_ct", bus_if.ciphertext, 128'd0);
        check_val("abort_busy", 128'(bus_if.busy), 128'd0);
        bus_if.out_ready = 1'b1;
        stale = 1'b0;
        repeat (15) begin
            tick();
            if (bus_if.out_valid) stale = 1'b1;
        end
        check_val("abort_stale", 128'(stale), 128'd0);
        bus_if.out_ready = 1'b0;
        run_block("abortC", KEY_C, PT_C, CT_C, 0, 1'b0, '0);

        // Reset and in_valid together: nothing accepted.
        rst               = 1'b1;
        bus_if.in_valid   = 1'b1;
        bus_if.plaintext  = PT_C;
        bus_if.round_keys = expand(KEY_C);
        tick();
        rst             = 1'b0;
        bus_if.in_valid = 1'b0;
        check_val("rstvld_rdy", 128'(bus_if.in_ready), 128'd1);
        tick();
        check_val("rstvld_busy", 128'(bus_if.busy), 128'd0);

        for (int i = 0; i < 8; i++) begin
            k = rand128();
            p = rand128();
            run_block($sformatf("rand%0d", i), k, p, model_encrypt(k, p),
                      $urandom_range(0, 3), 1'b0, '0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
